cvxc_axpy_stream: RTL and testbench
===================================

# cvxc_axpy_stream

Streaming, parametrised complex vector-times-constant accumulate block: result[i] = b[i] ± f(a[i]) · g(c) for NI lanes, with selectable conjugation of the vector operand and/or the constant. It supersedes the fixed 8-lane, free-running-counter style of vector/constant update used in the iterative solver datapath. It adds:
- valid/ready handshakes with backpressure;
- programmable batch length with a `finish` pulse;
- fixed-point rounding, plus optional saturation.

## Interface
Parameters:
- NI, 8, number of complex lanes
- EW, 64, complex element width; real = [EW-1:EW/2], imag = [EW/2-1:0], each signed two's complement, H = EW/2
- FRAC, 15, fractional right-shift applied to products (0..2H-1)
- CNT_W, 16, batch counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches batch config while idle
- batch_len  in  CNT_W  number of vectors in batch (sampled on start)
- op  in  1  0: b + p, 1: b − p (sampled on start)
- conj_mode  in  2  bit0 conjugate a, bit1 conjugate c (sampled on start)
- constant  in  EW  complex constant c (sampled on start)
- in_valid  in  1  a_vec/b_vec valid
- in_ready  out  1  block accepts vector this cycle
- a_vec  in  NI*EW  multiplicand vector, lane i at [EW*(i+1)-1 -: EW]
- b_vec  in  NI*EW  addend vector, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  NI*EW  result vector, same packing
- busy  out  1  state ≠ IDLE
- finish  out  1  one-cycle pulse after last result handshake

## Operation
- FSM states:
  - IDLE: start → RUN, latching batch_len, op, conj_mode and constant; in_cnt = out_cnt = 0.
  - If batch_len = 0: IDLE → DONE directly.
  - RUN: transitions to DONE in the cycle the out_cnt = batch_len−1 result handshakes.
  - DONE: finish = 1 for one cycle → IDLE.
- start outside IDLE is ignored. Latched config does not change mid-batch.
- Input acceptance: in_ready = RUN && in_cnt < batch_len && adv, where adv = !v3 || out_ready.
- Transfer on in_valid && in_ready; in_cnt increments.
- Three-stage pipeline, all stages enabled by adv (global stall). Valid bits v1..v3 shift on adv; bubbles propagate as invalid.
  - S1: register operands. Apply conjugation by negating the imag part.
  - S2: cross products ar·cr, ai·ci, ar·ci, ai·cr at 2H bits.
  - S3: pr = ar·cr − ai·ci, pi = ar·ci + ai·cr at 2H+1 bits. Round by adding 2^(FRAC−1) when FRAC > 0, then arithmetic shift right by FRAC. Add/subtract b with a delayed copy, and reduce to H bits (see Configuration).
- out_valid = v3; result is held stable while out_valid && !out_ready.
- out_cnt increments on each out_valid && out_ready.
- Reset values: in_ready 0, out_valid 0, result 0, busy 0, finish 0, all valid bits 0, FSM IDLE.

## Timing
- Latency: 3 cycles from input handshake to out_valid with no stall. Throughput: 1 vector/cycle.
- A stall holds all stages. No data is lost or duplicated.
- finish asserts the cycle after the last output handshake.
- busy drops in the same cycle finish is high.
- Assertion of reset at any time, including mid-batch, immediately clears all state. In-flight vectors are discarded and no finish is generated.
- Simultaneous input and output handshakes in the same cycle are legal.

## Configuration
- CVXC_SATURATE_EN defined:
  - Conjugating −2^(H−1) yields 2^(H−1)−1.
  - The final sum or difference is clamped to [−2^(H−1), 2^(H−1)−1] per real/imag component.
- CVXC_SATURATE_EN undefined:
  - Negation wraps.
  - The final result is truncated to the low H bits (two's-complement wrap).

## Test plan
All scenarios use EW=32 (H=16), FRAC=0, NI=2 unless stated otherwise.
- Plain product: start, len=1, op=0, conj=00, c=(1,2), a=(3,4), b=(10,10) all lanes → result (5,20) 3 cycles after accept, finish 1 cycle after handshake.
- Conjugation and subtract:
  - conj=01, op=0, same data → (21,12).
  - conj=00, op=1 → (15,0).
  - conj=11, op=0 → p=(−5,−10), result (5,0).
- Overflow: a=(32767,0), c=(2,0), b=(0,0), op=0 → 32767 with CVXC_SATURATE_EN, −2 (0xFFFE) without.
- Backpressure: len=4, continuous in_valid, out_ready low for 5 cycles mid-stream → in_ready drops, 4 results in order with no loss or duplication, exactly one finish.
- Edge cases:
  - len=0 → finish one cycle after start, in_ready never asserted.
  - start while busy → ignored.
  - FRAC=1, p=3 → rounds to 2.
- Reset mid-batch: assert reset after 2 of 4 vectors accepted → out_valid, busy, in_ready immediately 0, no finish. A new batch afterwards completes normally.

Source files
------------

// File: rtl/cvxc_axpy_stream.sv
// Streaming complex axpy: result[i] = b[i] +/- conj?(a[i]) * conj?(c), 3-stage pipeline with batch control.
// Optional macro CVXC_SATURATE_EN: saturating conjugation and saturating final sum/difference.
module cvxc_axpy_stream #(
  parameter int NI    = 8,
  parameter int EW    = 64,
  parameter int FRAC  = 15,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     batch_len,
  input  logic                 op,
  input  logic [1:0]           conj_mode,
  input  logic [EW-1:0]        constant,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NI*EW-1:0]     a_vec,
  input  logic [NI*EW-1:0]     b_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NI*EW-1:0]     result,
  output logic                 busy,
  output logic                 finish
);

  localparam int H  = EW / 2;
  localparam int PW = 2 * H + 2;  // product combine plus rounding headroom
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_len, r_in_cnt, r_out_cnt;
  logic             r_op;
  logic [1:0]       r_conj;
  logic [EW-1:0]    r_const;
  logic             r_v1, r_v2, r_v3;
  logic             w_adv, w_in_fire, w_out_fire, w_last_out;
  logic [H-1:0]     w_c_re, w_c_im;

  function automatic logic [H-1:0] f_neg(input logic [H-1:0] x);
    logic [H-1:0] n;
    n = -x;
`ifdef CVXC_SATURATE_EN
    if (x == {1'b1, {(H-1){1'b0}}}) n = {1'b0, {(H-1){1'b1}}};
`endif
    return n;
  endfunction

  function automatic logic [H-1:0] f_reduce(input logic [SW-1:0] s);
    logic [H-1:0] r;
    r = s[H-1:0];
`ifdef CVXC_SATURATE_EN
    if (s[SW-1:H-1] != {(SW-H+1){s[SW-1]}})
      r = s[SW-1] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
`endif
    return r;
  endfunction

  assign w_adv      = !r_v3 || out_ready;
  assign in_ready   = (r_state == S_RUN) && (r_in_cnt < r_len) && w_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign out_valid  = r_v3;
  assign w_out_fire = r_v3 && out_ready;
  assign w_last_out = w_out_fire && (r_out_cnt == r_len - CNT_W'(1));
  assign busy       = (r_state == S_RUN);
  assign finish     = (r_state == S_DONE);

  assign w_c_re = r_const[EW-1:H];
  assign w_c_im = r_conj[1] ? f_neg(r_const[H-1:0]) : r_const[H-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (batch_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_last_out) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len     <= '0;
      r_op      <= 1'b0;
      r_conj    <= '0;
      r_const   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_len     <= batch_len;
        r_op      <= op;
        r_conj    <= conj_mode;
        r_const   <= constant;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_fire)  r_in_cnt  <= r_in_cnt + CNT_W'(1);
        if (w_out_fire) r_out_cnt <= r_out_cnt + CNT_W'(1);
      end
      if (w_adv) begin
        r_v1 <= w_in_fire;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_lane
      logic [H-1:0]          w_a_re, w_a_im, w_b_re, w_b_im;
      logic [H-1:0]          r_ar, r_ai, r_br1, r_bi1, r_br2, r_bi2, r_res_re, r_res_im;
      logic signed [2*H-1:0] w_ar_x, w_ai_x, w_cr_x, w_ci_x;
      logic signed [2*H-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
      logic signed [PW-1:0]  w_pr, w_pi, w_pr_r, w_pi_r, w_pr_sh, w_pi_sh;
      logic [SW-1:0]         w_br_x, w_bi_x, w_sr, w_si;

      assign w_a_re = a_vec[EW*(gi+1)-1 -: H];
      assign w_a_im = a_vec[EW*gi+H-1 -: H];
      assign w_b_re = b_vec[EW*(gi+1)-1 -: H];
      assign w_b_im = b_vec[EW*gi+H-1 -: H];

      assign w_ar_x = {{H{r_ar[H-1]}}, r_ar};
      assign w_ai_x = {{H{r_ai[H-1]}}, r_ai};
      assign w_cr_x = {{H{w_c_re[H-1]}}, w_c_re};
      assign w_ci_x = {{H{w_c_im[H-1]}}, w_c_im};

      assign w_pr = {{2{r_p_rr[2*H-1]}}, r_p_rr} - {{2{r_p_ii[2*H-1]}}, r_p_ii};
      assign w_pi = {{2{r_p_ri[2*H-1]}}, r_p_ri} + {{2{r_p_ir[2*H-1]}}, r_p_ir};

      if (FRAC > 0) begin : g_rnd
        assign w_pr_r = w_pr + (PW'(1) << (FRAC - 1));
        assign w_pi_r = w_pi + (PW'(1) << (FRAC - 1));
      end else begin : g_nornd
        assign w_pr_r = w_pr;
        assign w_pi_r = w_pi;
      end

      assign w_pr_sh = w_pr_r >>> FRAC;
      assign w_pi_sh = w_pi_r >>> FRAC;
      assign w_br_x  = {{(SW-H){r_br2[H-1]}}, r_br2};
      assign w_bi_x  = {{(SW-H){r_bi2[H-1]}}, r_bi2};
      assign w_sr    = r_op ? w_br_x - {w_pr_sh[PW-1], w_pr_sh} : w_br_x + {w_pr_sh[PW-1], w_pr_sh};
      assign w_si    = r_op ? w_bi_x - {w_pi_sh[PW-1], w_pi_sh} : w_bi_x + {w_pi_sh[PW-1], w_pi_sh};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ar     <= '0;
          r_ai     <= '0;
          r_br1    <= '0;
          r_bi1    <= '0;
          r_br2    <= '0;
          r_bi2    <= '0;
          r_p_rr   <= '0;
          r_p_ii   <= '0;
          r_p_ri   <= '0;
          r_p_ir   <= '0;
          r_res_re <= '0;
          r_res_im <= '0;
        end else begin
          if (w_in_fire) begin
            r_ar  <= w_a_re;
            r_ai  <= r_conj[0] ? f_neg(w_a_im) : w_a_im;
            r_br1 <= w_b_re;
            r_bi1 <= w_b_im;
          end
          if (w_adv && r_v1) begin
            r_p_rr <= w_ar_x * w_cr_x;
            r_p_ii <= w_ai_x * w_ci_x;
            r_p_ri <= w_ar_x * w_ci_x;
            r_p_ir <= w_ai_x * w_cr_x;
            r_br2  <= r_br1;
            r_bi2  <= r_bi1;
          end
          if (w_adv && r_v2) begin
            r_res_re <= f_reduce(w_sr);
            r_res_im <= f_reduce(w_si);
          end
        end
      end

      assign result[EW*(gi+1)-1 -: EW] = {r_res_re, r_res_im};
    end
  endgenerate

endmodule

// File: tb/tb_cvxc_axpy_stream.sv
// Directed bench for cvxc_axpy_stream (NI=2, EW=32); a second instance with FRAC=1 covers rounding.
module tb_cvxc_axpy_stream;
  localparam int NI = 2, EW = 32, CNT_W = 16;

  logic             clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [CNT_W-1:0] batch_len = '0;
  logic             op = 1'b0;
  logic [1:0]       conj_mode = '0;
  logic [EW-1:0]    constant = '0;
  logic             in_valid = 1'b0, out_ready = 1'b1;
  logic [NI*EW-1:0] a_vec = '0, b_vec = '0;
  logic             in_ready, out_valid, busy, finish;
  logic [NI*EW-1:0] result;
  logic             f1_in_ready, f1_out_valid, f1_busy, f1_finish;
  logic [NI*EW-1:0] f1_result;
  logic [NI*EW-1:0] last_f1;

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  cvxc_axpy_stream #(.NI(NI), .EW(EW), .FRAC(0), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .batch_len(batch_len), .op(op),
    .conj_mode(conj_mode), .constant(constant), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .finish(finish));

  cvxc_axpy_stream #(.NI(NI), .EW(EW), .FRAC(1), .CNT_W(CNT_W)) u_dut_f1 (
    .clk(clk), .reset(reset), .start(start), .batch_len(batch_len), .op(op),
    .conj_mode(conj_mode), .constant(constant), .in_valid(in_valid), .in_ready(f1_in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(f1_out_valid), .out_ready(out_ready),
    .result(f1_result), .busy(f1_busy), .finish(f1_finish));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lane 1 in the upper word, each lane packed {re, im}
  function automatic logic [63:0] pk(input int l1re, input int l1im, input int l0re, input int l0im);
    return {16'(l1re), 16'(l1im), 16'(l0re), 16'(l0im)};
  endfunction

  task automatic single_vec(input string tag, input logic o, input logic [1:0] cm,
                            input logic [31:0] c, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp, input bit poke);
    int n;
    @(negedge clk);
    start = 1'b1; batch_len = 16'd1; op = o; conj_mode = cm; constant = c;
    @(negedge clk);
    start = poke;
    if (poke) begin
      batch_len = 16'd0; op = ~o; conj_mode = ~cm; constant = 32'h0005_0005;
    end
    in_valid = 1'b1; a_vec = a; b_vec = b;
    #1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    n = 1; #1;
    while (!out_valid && n < 12) begin @(negedge clk); #1; n++; end
    check({tag, "_latency"}, 64'(n), 64'd3);
    check({tag, "_result"}, result, exp);
    last_f1 = f1_result;
    $display("xfer %s result=%h", tag, result);
    @(negedge clk); #1;
    check({tag, "_finish"}, 64'(finish), 64'd1);
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(negedge clk); #1;
    check({tag, "_finish_pulse"}, 64'(finish), 64'd0);
  endtask

  logic [63:0] bp_a [4];
  logic [63:0] bp_b [4];
  logic [63:0] bp_e [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_in, idx_out, fin, acc, n;
    bit saw_drop;
    logic [63:0] exp_ovf;

    bp_a[0] = pk(10, -1, 1, 2); bp_a[1] = pk(11, -1, 2, 3);
    bp_a[2] = pk(12, -1, 3, 4); bp_a[3] = pk(13, -1, 4, 5);
    for (int k = 0; k < 4; k++) bp_b[k] = pk(0, 50, 1000, 0);
    bp_e[0] = pk(20, 48, 1002, 4); bp_e[1] = pk(22, 48, 1004, 6);
    bp_e[2] = pk(24, 48, 1006, 8); bp_e[3] = pk(26, 48, 1008, 10);

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    reset = 1'b1;

    single_vec("plain", 1'b0, 2'b00, 32'h0001_0002, pk(1, 1, 3, 4), pk(10, 10, 10, 10),
               pk(9, 13, 5, 20), 1'b0);
    single_vec("conj_a", 1'b0, 2'b01, 32'h0001_0002, pk(3, 4, 3, 4), pk(10, 10, 10, 10),
               pk(21, 12, 21, 12), 1'b0);
    single_vec("sub", 1'b1, 2'b00, 32'h0001_0002, pk(3, 4, 3, 4), pk(10, 10, 10, 10),
               pk(15, 0, 15, 0), 1'b0);
    single_vec("conj_ac", 1'b0, 2'b11, 32'h0001_0002, pk(3, 4, 3, 4), pk(10, 10, 10, 10),
               pk(5, 0, 5, 0), 1'b0);
`ifdef CVXC_SATURATE_EN
    exp_ovf = pk(32767, 0, 32767, 0);
`else
    exp_ovf = pk(-2, 0, -2, 0);
`endif
    single_vec("overflow", 1'b0, 2'b00, 32'h0002_0000, pk(32767, 0, 32767, 0), 64'd0,
               exp_ovf, 1'b0);
    single_vec("frac", 1'b0, 2'b00, 32'h0001_0000, pk(-3, 5, 3, 0), 64'd0,
               pk(-3, 5, 3, 0), 1'b0);
    check("frac1_round", last_f1, pk(-1, 3, 2, 0));
    single_vec("start_busy", 1'b0, 2'b00, 32'h0001_0002, pk(3, 4, 3, 4), pk(10, 10, 10, 10),
               pk(5, 20, 5, 20), 1'b1);

    // zero-length batch
    @(negedge clk);
    start = 1'b1; batch_len = 16'd0;
    @(negedge clk);
    start = 1'b0; #1;
    check("len0_finish", 64'(finish), 64'd1);
    check("len0_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); #1;
    check("len0_finish_pulse", 64'(finish), 64'd0);
    check("len0_in_ready2", 64'(in_ready), 64'd0);

    // backpressure: 4 vectors, out_ready low for 5 cycles mid-stream
    @(negedge clk);
    start = 1'b1; batch_len = 16'd4; op = 1'b0; conj_mode = 2'b00; constant = 32'h0002_0000;
    idx_in = 0; idx_out = 0; fin = 0; saw_drop = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (finish) fin++;
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid = (idx_in < 4);
      if (idx_in < 4) begin a_vec = bp_a[idx_in]; b_vec = bp_b[idx_in]; end
      #1;
      if (out_valid) begin
        if (idx_out < 4) check("bp_result", result, bp_e[idx_out]);
        else check("bp_extra_output", 64'(out_valid), 64'd0);
      end
      if (out_valid && out_ready) begin
        $display("xfer bp idx=%0d result=%h", idx_out, result);
        idx_out++;
      end
      if (in_valid && !in_ready && busy) saw_drop = 1'b1;
      if (in_valid && in_ready) idx_in++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_inputs", 64'(idx_in), 64'd4);
    check("bp_outputs", 64'(idx_out), 64'd4);
    check("bp_finish_count", 64'(fin), 64'd1);
    check("bp_ready_drop", 64'(saw_drop), 64'd1);

    // reset in the middle of a batch
    @(negedge clk);
    start = 1'b1; batch_len = 16'd4; constant = 32'h0001_0000; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; a_vec = pk(1, 1, 1, 1); b_vec = 64'd0;
    acc = 0; n = 0;
    while (acc < 2 && n < 20) begin
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    n = 0; #1;
    while (!out_valid && n < 10) begin @(negedge clk); #1; n++; end
    check("mid_out_valid_before", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    fin = 0;
    repeat (8) begin @(negedge clk); if (finish) fin++; end
    check("mid_rst_no_finish", 64'(fin), 64'd0);
    single_vec("after_rst", 1'b0, 2'b00, 32'h0001_0002, pk(1, 1, 3, 4), pk(10, 10, 10, 10),
               pk(9, 13, 5, 20), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
